// File: rtl/sine_voice_pkg.sv
// sine_voice_pkg: shared widths and FSM encoding for the sine voice scheduler.
package sine_voice_pkg;
    localparam int PHASE_W    = 32;
    localparam int LUT_ADDR_W = 16;
    localparam int LUT_DATA_W = 16;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/sine_voice_scheduler_if.sv
// sine_voice_scheduler_if: tick, config, LUT and mix signals of the scheduler.
// i_gate exists only when SINE_VOICE_GATE_EN is defined.
interface sine_voice_scheduler_if #(
    parameter int NUM_VOICES = 4,
    parameter int MIX_W      = 16 + $clog2(NUM_VOICES)
);
    logic                                  i_sample_tick;
    logic                                  i_cfg_we;
    logic [$clog2(NUM_VOICES)-1:0]         i_cfg_voice;
    logic [sine_voice_pkg::PHASE_W-1:0]    i_cfg_inc;
    logic [sine_voice_pkg::LUT_ADDR_W-1:0] o_lut_addr;
    logic [sine_voice_pkg::LUT_DATA_W-1:0] i_lut_data;
    logic [MIX_W-1:0]                      o_mix;
    logic                                  o_valid;
    logic                                  o_busy;
    logic                                  o_overrun;
`ifdef SINE_VOICE_GATE_EN
    logic [NUM_VOICES-1:0]                 i_gate;
`endif
    modport master (
        output i_sample_tick, i_cfg_we, i_cfg_voice, i_cfg_inc, i_lut_data,
`ifdef SINE_VOICE_GATE_EN
        output i_gate,
`endif
        input  o_lut_addr, o_mix, o_valid, o_busy, o_overrun
    );
    modport slave (
        input  i_sample_tick, i_cfg_we, i_cfg_voice, i_cfg_inc, i_lut_data,
`ifdef SINE_VOICE_GATE_EN
        input  i_gate,
`endif
        output o_lut_addr, o_mix, o_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/sine_voice_phase_bank.sv
// sine_voice_phase_bank: per-voice tuning words and phase accumulators.
// With SINE_VOICE_GATE_EN, a voice advanced with keep=0 has its phase cleared.
module sine_voice_phase_bank
    import sine_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          we,
    input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
    input  logic [PHASE_W-1:0]            wr_inc,
    input  logic                          adv,
    input  logic [$clog2(NUM_VOICES)-1:0] sel,
`ifdef SINE_VOICE_GATE_EN
    input  logic                          keep,
`endif
    output logic [PHASE_W-1:0]            rd_phase
);
    logic [PHASE_W-1:0] inc   [NUM_VOICES];
    logic [PHASE_W-1:0] phase [NUM_VOICES];

    assign rd_phase = phase[sel];

    // The advance reads inc before this cycle's write lands, so a same-cycle write waits a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc[i]   <= '0;
                phase[i] <= '0;
            end
        end else begin
            if (we) inc[wr_voice] <= wr_inc;
`ifdef SINE_VOICE_GATE_EN
            if (adv) phase[sel] <= keep ? phase[sel] + inc[sel] : '0;
`else
            if (adv) phase[sel] <= phase[sel] + inc[sel];
`endif
        end
    end
endmodule

// File: rtl/sine_voice_scheduler.sv
// sine_voice_scheduler: shares one registered sine LUT among NUM_VOICES voices and mixes them.
// Optional per-voice gating via SINE_VOICE_GATE_EN.
module sine_voice_scheduler
    import sine_voice_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int LUT_LATENCY = 1,
    parameter int MIX_W       = 16 + $clog2(NUM_VOICES)
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    sine_voice_scheduler_if.slave bus
);
    localparam int VW = $clog2(NUM_VOICES);

    logic [1:0]             state;
    logic [VW-1:0]          k;
    logic [LUT_LATENCY:0]   vld;
    logic [LUT_LATENCY:0]   en;
    logic [MIX_W-1:0]       acc;
    logic [MIX_W-1:0]       acc_nxt;
    logic [MIX_W-1:0]       sample;
    logic [PHASE_W-1:0]     rd_phase;
    logic                   issue;
    logic                   keep;
    logic                   last;

    assign issue   = state == S_ISSUE;
`ifdef SINE_VOICE_GATE_EN
    assign keep    = bus.i_gate[k];
`else
    assign keep    = 1'b1;
`endif
    assign sample  = {{(MIX_W-LUT_DATA_W){bus.i_lut_data[LUT_DATA_W-1]}}, bus.i_lut_data};
    assign acc_nxt = acc + ((vld[LUT_LATENCY] && en[LUT_LATENCY]) ? sample : '0);
    // Tags are contiguous and nothing issues in DRAIN, so the oldest tag alone marks the final capture.
    assign last    = vld[LUT_LATENCY] && !(|vld[LUT_LATENCY-1:0]);

    sine_voice_phase_bank #(.NUM_VOICES(NUM_VOICES)) u_bank (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .we       (bus.i_cfg_we),
        .wr_voice (bus.i_cfg_voice),
        .wr_inc   (bus.i_cfg_inc),
        .adv      (issue),
        .sel      (k),
`ifdef SINE_VOICE_GATE_EN
        .keep     (keep),
`endif
        .rd_phase (rd_phase)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            k              <= '0;
            vld            <= '0;
            en             <= '0;
            acc            <= '0;
            bus.o_lut_addr <= '0;
            bus.o_mix      <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_overrun  <= 1'b0;
        end else begin
            vld         <= {vld[LUT_LATENCY-1:0], issue};
            en          <= {en[LUT_LATENCY-1:0], issue & keep};
            acc         <= acc_nxt;
            bus.o_valid <= 1'b0;
            if (bus.i_sample_tick && state != S_IDLE) bus.o_overrun <= 1'b1;
            if (issue) bus.o_lut_addr <= rd_phase[PHASE_W-1 -: LUT_ADDR_W];
            case (state)
                S_IDLE: if (bus.i_sample_tick) begin
                    state      <= S_ISSUE;
                    k          <= '0;
                    acc        <= '0;
                    bus.o_busy <= 1'b1;
                end
                S_ISSUE: begin
                    k <= k + 1'b1;
                    if (k == VW'(NUM_VOICES - 1)) state <= S_DRAIN;
                end
                S_DRAIN: if (last) begin
                    state       <= S_DONE;
                    bus.o_mix   <= acc_nxt;
                    bus.o_valid <= 1'b1;
                    bus.o_busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sine_voice_scheduler.sv
// tb_sine_voice_scheduler: directed checks of the sine voice scheduler (4 voices, LUT latency 1).
// Gate checks are compiled in only when SINE_VOICE_GATE_EN is defined.
module tb_sine_voice_scheduler;
    localparam int NV = 4;
    localparam int MW = 18;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b1;
    int          cmp     = 0;
    int          bad     = 0;
    int          mode    = 0;
    logic [15:0] lut_q   = '0;

    sine_voice_scheduler_if #(.NUM_VOICES(NV), .MIX_W(MW)) bus ();

    sine_voice_scheduler #(.NUM_VOICES(NV), .LUT_LATENCY(1), .MIX_W(MW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    // Registered LUT stand-in: echoes the address, or a fixed value for sign/gate tests.
    always @(posedge i_clk) lut_q <= (mode == 0) ? bus.o_lut_addr : (mode == 1) ? 16'h8000 : 16'd100;
    assign bus.i_lut_data = lut_q;

    task automatic do_reset();
        @(negedge i_clk) i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] v, input logic [31:0] inc);
        @(negedge i_clk);
        bus.i_cfg_we = 1'b1; bus.i_cfg_voice = v; bus.i_cfg_inc = inc;
        @(negedge i_clk) bus.i_cfg_we = 1'b0;
    endtask

    task automatic do_frame(output logic [MW-1:0] mix, output int lat, output logic [3:0][15:0] addrs, output logic v_after);
        lat = 0; addrs = '0; mix = '0;
        @(negedge i_clk) bus.i_sample_tick = 1'b1;
        @(posedge i_clk);
        #1 bus.i_sample_tick = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge i_clk);
            #1;
            if (n <= 4) addrs[n-1] = bus.o_lut_addr;
            if (bus.o_valid) begin lat = n; mix = bus.o_mix; break; end
        end
        @(posedge i_clk);
        #1 v_after = bus.o_valid;
    endtask

    task automatic test_reset();
        #3 i_rst_n = 1'b0;
        #1;
        cmp++; if (bus.o_lut_addr !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", bus.o_lut_addr); end
        cmp++; if (bus.o_mix !== 18'h0) begin bad++; $display("FAIL reset_mix: got %h want 00000", bus.o_mix); end
        cmp++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        cmp++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        cmp++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.o_overrun); end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_single_voice();
        logic [MW-1:0] mix; int lat; logic [3:0][15:0] a; logic va;
        do_reset();
        cfg(2'd0, 32'h0001_0000);
        for (int f = 0; f < 3; f++) begin
            do_frame(mix, lat, a, va);
            cmp++; if (lat != 6) begin bad++; $display("FAIL single_latency f%0d: got %0d want 6", f, lat); end
            cmp++; if (a[0] !== 16'(f)) begin bad++; $display("FAIL single_addr f%0d: got %h want %h", f, a[0], 16'(f)); end
            cmp++; if (mix !== MW'(f)) begin bad++; $display("FAIL single_mix f%0d: got %h want %h", f, mix, MW'(f)); end
            cmp++; if (va !== 1'b0) begin bad++; $display("FAIL single_pulse f%0d: got %b want 0", f, va); end
        end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] mix; int lat; logic [3:0][15:0] a; logic va;
        do_reset();
        for (int v = 0; v < NV; v++) cfg(2'(v), 32'(v + 1) << 16);
        do_frame(mix, lat, a, va);
        do_frame(mix, lat, a, va);
        for (int v = 0; v < NV; v++) begin
            cmp++; if (a[v] !== 16'(v + 1)) begin bad++; $display("FAIL b2b_addr v%0d: got %h want %h", v, a[v], 16'(v + 1)); end
        end
        cmp++; if (mix !== 18'd10) begin bad++; $display("FAIL b2b_mix: got %h want 0000a", mix); end
    endtask

    task automatic test_wrap();
        logic [MW-1:0] mix; int lat; logic [3:0][15:0] a; logic va;
        do_reset();
        cfg(2'd0, 32'hFFFF_0000);
        do_frame(mix, lat, a, va);
        cfg(2'd0, 32'h0001_0000);
        do_frame(mix, lat, a, va);
        cmp++; if (a[0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr_hi: got %h want ffff", a[0]); end
        cmp++; if (mix !== 18'h3FFFF) begin bad++; $display("FAIL wrap_mix_neg1: got %h want 3ffff", mix); end
        do_frame(mix, lat, a, va);
        cmp++; if (a[0] !== 16'h0000) begin bad++; $display("FAIL wrap_addr_lo: got %h want 0000", a[0]); end
        cmp++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL wrap_overrun: got %b want 0", bus.o_overrun); end
    endtask

    task automatic test_overrun();
        int nv = 0;
        do_reset();
        @(negedge i_clk) bus.i_sample_tick = 1'b1;
        @(negedge i_clk) bus.i_sample_tick = 1'b0;
        @(negedge i_clk) bus.i_sample_tick = 1'b1;
        @(negedge i_clk) bus.i_sample_tick = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge i_clk);
            #1 if (bus.o_valid) nv++;
        end
        cmp++; if (nv != 1) begin bad++; $display("FAIL overrun_valid_count: got %0d want 1", nv); end
        cmp++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", bus.o_overrun); end
        repeat (10) @(negedge i_clk);
        cmp++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", bus.o_overrun); end
        do_reset();
        #1;
        cmp++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL overrun_cleared: got %b want 0", bus.o_overrun); end
    endtask

    task automatic test_sign_ext();
        logic [MW-1:0] mix; int lat; logic [3:0][15:0] a; logic va;
        do_reset();
        mode = 1;
        do_frame(mix, lat, a, va);
        mode = 0;
        cmp++; if (mix !== 18'h20000) begin bad++; $display("FAIL sign_ext_mix: got %h want 20000", mix); end
    endtask

    task automatic test_reset_mid_frame();
        logic [MW-1:0] mix; int lat; logic [3:0][15:0] a; logic va; int nv = 0;
        do_reset();
        for (int v = 0; v < NV; v++) cfg(2'(v), 32'(v + 1) << 16);
        do_frame(mix, lat, a, va);
        do_frame(mix, lat, a, va);
        @(negedge i_clk) bus.i_sample_tick = 1'b1;
        @(posedge i_clk);
        #1 bus.i_sample_tick = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst_n = 1'b0;
        #1;
        cmp++; if (bus.o_lut_addr !== 16'h0) begin bad++; $display("FAIL midrst_addr: got %h want 0000", bus.o_lut_addr); end
        cmp++; if (bus.o_mix !== 18'h0) begin bad++; $display("FAIL midrst_mix: got %h want 00000", bus.o_mix); end
        cmp++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
        cmp++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.o_valid); end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge i_clk);
            #1 if (bus.o_valid) nv++;
        end
        cmp++; if (nv != 0) begin bad++; $display("FAIL midrst_no_valid: got %0d want 0", nv); end
        cfg(2'd0, 32'h0001_0000);
        do_frame(mix, lat, a, va);
        cmp++; if (a[0] !== 16'h0) begin bad++; $display("FAIL midrst_phase0: got %h want 0000", a[0]); end
        cmp++; if (a[2] !== 16'h0) begin bad++; $display("FAIL midrst_phase2: got %h want 0000", a[2]); end
        cmp++; if (lat != 6) begin bad++; $display("FAIL midrst_latency: got %0d want 6", lat); end
    endtask

`ifdef SINE_VOICE_GATE_EN
    task automatic test_gate();
        logic [MW-1:0] mix; int lat; logic [3:0][15:0] a; logic va;
        do_reset();
        for (int v = 0; v < NV; v++) cfg(2'(v), 32'h0001_0000);
        mode = 2;
        bus.i_gate = 4'b0101;
        do_frame(mix, lat, a, va);
        mode = 0;
        bus.i_gate = 4'b1111;
        cmp++; if (mix !== 18'd200) begin bad++; $display("FAIL gate_mix: got %0d want 200", mix); end
        do_frame(mix, lat, a, va);
        cmp++; if (a !== {16'h0, 16'h1, 16'h0, 16'h1}) begin bad++; $display("FAIL gate_phase: got %h want 0000000100000001", a); end
    endtask
`endif

    initial begin
        bus.i_sample_tick = 1'b0;
        bus.i_cfg_we      = 1'b0;
        bus.i_cfg_voice   = '0;
        bus.i_cfg_inc     = '0;
`ifdef SINE_VOICE_GATE_EN
        bus.i_gate        = '1;
`endif
        test_reset();
        test_single_voice();
        test_back_to_back();
        test_wrap();
        test_overrun();
        test_sign_ext();
        test_reset_mid_frame();
`ifdef SINE_VOICE_GATE_EN
        test_gate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
